fetch_unit: RTL and testbench

//  Pipelined, parametrised instruction-fetch stage: owns the PC register, issues word-address

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fetch_pkg: shared widths and PC arithmetic for the fetch stage |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package fetch_pkg;

  localparam int unsigned AW_DEF    = 30;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned PC_CALC_W = 64;

  // Callers truncate the result to their PC width, which gives modulo-2^AW wrap.
  function automatic logic [PC_CALC_W-1:0] pc_add(input logic [PC_CALC_W-1:0] pc,
                                                  input logic [PC_CALC_W-1:0] off);
    return pc + off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fetch_fifo: registered sync FIFO with flush, count, full/empty  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module fetch_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && !flush && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head reads as zero while empty so downstream sees clean reset values.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fetch_unit: PC register, imem request credit, redirect handling |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   DW       = DW_DEF,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_resp_valid,
  input  logic [DW-1:0] imem_resp_data,
  input  logic          redirect_valid,
  input  logic          redirect_jump,
  input  logic [AW-1:0] jump_tgt,
  input  logic [AW-1:0] branch_pc,
  input  logic [AW-1:0] branch_offset,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  output logic [AW-1:0] inst_pc4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]        fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic                 started_q, started_d;

  logic [CW-1:0]        buf_count, outstanding;
  logic                 buf_full, buf_empty, pcq_full, pcq_empty;
  logic [AW+DW-1:0]     buf_head;
  logic [AW-1:0]        pcq_head;
  logic [CW:0]          credit_sum;
  logic                 req_fire, resp_take, resp_keep, inst_pop;
  logic [AW-1:0]        redirect_tgt;
  logic [PC_CALC_W-1:0] tgt_sum, pc_inc_sum, pc4_sum;
  logic                 unused_bits;

  always_comb begin
    tgt_sum        = pc_add(PC_CALC_W'(branch_pc), PC_CALC_W'(branch_offset));
    pc_inc_sum     = pc_add(PC_CALC_W'(fetch_pc_q), PC_CALC_W'(1));
    pc4_sum        = pc_add(PC_CALC_W'(inst_pc), PC_CALC_W'(1));
    redirect_tgt   = redirect_jump ? jump_tgt : tgt_sum[AW-1:0];

    // Stale in-flight requests still hold credit until their responses drain.
    credit_sum     = {1'b0, buf_count} + {1'b0, outstanding};
    imem_req_valid = started_q && (credit_sum < (CW+1)'(DEPTH)) && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_take      = imem_resp_valid && !pcq_empty;
    resp_keep      = resp_take && (drop_q == '0) && !redirect_valid;
    inst_pop       = inst_valid && inst_ready && !redirect_valid;

    started_d      = 1'b1;
    fetch_pc_d     = fetch_pc_q;
    drop_d         = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d     = outstanding - CW'(resp_take);
    end else begin
      if (req_fire) begin
        fetch_pc_d = pc_inc_sum[AW-1:0];
      end
      if (resp_take && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      started_q  <= started_d;
    end
  end

  // Request-PC queue: one entry per in-flight request, so its count is the outstanding total.
  fetch_fifo #(
    .W     (AW),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (resp_take),
    .rd_data   (pcq_head),
    .count     (outstanding),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data ({pcq_head, imem_resp_data}),
    .pop       (inst_pop),
    .rd_data   (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign imem_req_addr = fetch_pc_q;
  assign inst_valid    = !buf_empty;
  assign inst_pc       = buf_head[AW+DW-1:DW];
  assign inst_data     = buf_head[DW-1:0];
  assign inst_pc4      = inst_valid ? pc4_sum[AW-1:0] : '0;

  assign unused_bits = &{1'b0, buf_full, pcq_full,
                         tgt_sum[PC_CALC_W-1:AW], pc_inc_sum[PC_CALC_W-1:AW],
                         pc4_sum[PC_CALC_W-1:AW]};

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_fetch_unit: imem model, scoreboard and redirect vector table |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_fetch_unit;

  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] RST_PC = 30'h100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [DW-1:0] imem_resp_data;
  logic          redirect_valid, redirect_jump;
  logic [AW-1:0] jump_tgt, branch_pc, branch_offset;
  logic          inst_valid, inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc, inst_pc4;

  always #5 clk = ~clk;

  fetch_unit #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_jump(redirect_jump),
    .jump_tgt(jump_tgt), .branch_pc(branch_pc), .branch_offset(branch_offset),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc4(inst_pc4)
  );

  typedef struct { logic [AW-1:0] addr; int ep; int due; } pend_t;
  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] data; } inst_t;
  typedef struct {
    logic jump; logic [AW-1:0] jt; logic [AW-1:0] bpc; logic [AW-1:0] off;
    logic [AW-1:0] tgt; int lat;
  } vec_t;

  pend_t pend[$];
  inst_t sb[$];
  vec_t  vecs[5];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, epoch = 0, lat = 1, n_fire = 0, n_pop = 0;
  bit started = 1'b0, got_first = 1'b0;
  logic [AW-1:0] exp_pc, first_pc;
  logic nx_redir, nx_jump, nx_ready, nx_iready;
  logic [AW-1:0] nx_jt, nx_bpc, nx_off, nx_tgt;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {a, 2'b10} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_req_addr"}, 64'(imem_req_addr), 64'(RST_PC));
    chk({tag, "_inst_data"}, 64'(inst_data), 64'd0);
    chk({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
    chk({tag, "_inst_pc4"}, 64'(inst_pc4), 64'd0);
  endtask

  // One clock: drive at negedge, sample 1 unit later, update imem model and scoreboard.
  task automatic step();
    pend_t p;
    inst_t e;
    logic rsp;
    logic [AW-1:0] pc4;
    @(negedge clk);
    redirect_valid = nx_redir; redirect_jump = nx_jump; jump_tgt = nx_jt;
    branch_pc = nx_bpc; branch_offset = nx_off;
    imem_req_ready = nx_ready; inst_ready = nx_iready;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? word(pend[0].addr) : '0;
    #1;
    chk("req_valid", 64'(imem_req_valid),
        64'(started && ((sb.size() + pend.size()) < DEPTH) && !nx_redir));
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", 64'(imem_req_addr), 64'(exp_pc));
      pend.push_back('{addr: exp_pc, ep: epoch, due: cyc + lat});
      exp_pc = exp_pc + AW'(1);
      n_fire++;
    end
    chk("inst_valid", 64'(inst_valid), 64'(sb.size() > 0));
    if (inst_valid && inst_ready && !nx_redir) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pop: got pc %h expected no instruction", inst_pc);
      end else begin
        e   = sb.pop_front();
        pc4 = e.pc + AW'(1);
        chk("inst_pc", 64'(inst_pc), 64'(e.pc));
        chk("inst_data", 64'(inst_data), 64'(e.data));
        chk("inst_pc4", 64'(inst_pc4), 64'(pc4));
        n_pop++;
        if (!got_first) begin
          got_first = 1'b1;
          first_pc  = inst_pc;
        end
      end
    end
    if (rsp) begin
      p = pend.pop_front();
      if (p.ep == epoch && !nx_redir) sb.push_back('{pc: p.addr, data: word(p.addr)});
    end
    if (nx_redir) begin
      sb.delete();
      epoch++;
      exp_pc    = nx_tgt;
      got_first = 1'b0;
    end
    @(posedge clk);
    cyc++;
    started = 1'b1;
  endtask

  task automatic do_redirect(input logic j, input logic [AW-1:0] jt, input logic [AW-1:0] bpc,
                             input logic [AW-1:0] off, input logic [AW-1:0] tgt);
    nx_redir = 1'b1; nx_jump = j; nx_jt = jt; nx_bpc = bpc; nx_off = off; nx_tgt = tgt;
    step();
    nx_redir = 1'b0;
  endtask

  task automatic wait_first(input string nm, input logic [AW-1:0] tgt);
    for (int k = 0; k < 40 && !got_first; k++) step();
    chk(nm, got_first ? 64'(first_pc) : 64'hDEAD_0000_0000_0000, 64'(tgt));
  endtask

  task automatic model_reset();
    pend.delete(); sb.delete();
    exp_pc = RST_PC; started = 1'b0; got_first = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{jump: 1'b1, jt: 30'h2000, bpc: 30'h7,         off: 30'h5,         tgt: 30'h2000,     lat: 3};
    vecs[1] = '{jump: 1'b0, jt: 30'h1234, bpc: 30'h40,        off: 30'h3FFF_FFFC, tgt: 30'h3C,       lat: 1};
    vecs[2] = '{jump: 1'b1, jt: 30'h0AAA, bpc: 30'h40,        off: 30'h8,         tgt: 30'hAAA,      lat: 2};
    vecs[3] = '{jump: 1'b0, jt: 30'h0,    bpc: 30'h3FFF_FFF0, off: 30'h20,        tgt: 30'h10,       lat: 2};
    vecs[4] = '{jump: 1'b1, jt: 30'h3FFF_FFFE, bpc: 30'h100,  off: 30'h1,         tgt: 30'h3FFF_FFFE, lat: 1};

    nx_redir = 0; nx_jump = 0; nx_jt = '0; nx_bpc = '0; nx_off = '0; nx_tgt = '0;
    nx_ready = 1; nx_iready = 1;
    redirect_valid = 0; redirect_jump = 0; jump_tgt = '0; branch_pc = '0; branch_offset = '0;
    imem_req_ready = 0; inst_ready = 0;
    model_reset();
    rst_n = 1'b0;
    #23;
    check_reset("rst");
    @(posedge clk); #2 rst_n = 1'b1;

    // Sequential streaming, latency 1
    lat = 1;
    repeat (20) step();
    chk("stream_pops", 64'(n_pop >= 8), 64'd1);
    chk("stream_first_pc", 64'(first_pc), 64'(RST_PC));

    // Decode stalled: credit limits new requests to DEPTH
    nx_iready = 0;
    do_redirect(1'b1, 30'h800, '0, '0, 30'h800);
    n_fire = 0;
    repeat (12) step();
    chk("stall_fires", 64'(n_fire), 64'(DEPTH));
    nx_iready = 1;
    wait_first("stall_release_pc", 30'h800);
    repeat (6) step();

    // Redirect vector table
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      repeat (6) step();
      do_redirect(vecs[i].jump, vecs[i].jt, vecs[i].bpc, vecs[i].off, vecs[i].tgt);
      wait_first($sformatf("vec%0d_first_pc", i), vecs[i].tgt);
      repeat (6) step();
    end

    // Back-to-back redirects: only the second target survives
    lat = 2;
    repeat (6) step();
    do_redirect(1'b1, 30'h500, '0, '0, 30'h500);
    do_redirect(1'b0, 30'h500, 30'h600, 30'h0, 30'h600);
    wait_first("b2b_first_pc", 30'h600);
    repeat (6) step();

    // Random imem and decode backpressure
    for (int i = 0; i < 30; i++) begin
      nx_ready  = 1'($urandom_range(0, 1));
      nx_iready = 1'($urandom_range(0, 1));
      step();
    end
    nx_ready = 1; nx_iready = 1;
    repeat (8) step();

    // Asynchronous reset with responses still pending
    lat = 3;
    repeat (5) step();
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    model_reset();
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    lat = 1;
    wait_first("post_reset_first_pc", RST_PC);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
